// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED state encoding and RGB565 field constants
package led_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FADE = 2'd1,
      HOLD = 2'd2
   } led_state_e;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   localparam int R_W = 5;
   localparam int G_W = 6;
   localparam int B_W = 5;

endpackage

// File: rtl/led_channel_ramp.sv
// rtl/led_channel_ramp.sv - one colour channel moved by one unit toward its target
module led_channel_ramp #(
   parameter int W = 5
) (
   input  logic [W-1:0] cur,
   input  logic [W-1:0] tgt,
   input  logic         step_en,
   output logic [W-1:0] next,
   output logic         at_tgt
);

   // Compare before stepping so the value can never pass the target or wrap.
   always_comb begin
      next   = cur;
      at_tgt = (cur == tgt);
      if (step_en) begin
         if (cur < tgt) begin
            next = cur + W'(1);
         end else if (cur > tgt) begin
            next = cur - W'(1);
         end
      end
   end

endmodule

// File: rtl/led_color_sequencer.sv
// rtl/led_color_sequencer.sv - manual/auto RGB565 colour source for the PWM LED block
module led_color_sequencer
   import led_pkg::*;
#(
   parameter int NUM_ENTRIES  = 4,
   parameter int IDX_W        = 2,
   parameter int STEP_CYCLES  = 16,
   parameter int DWELL_CYCLES = 1000,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      switchPanel,
   input  logic             start,
   input  logic             stop,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [15:0]      wr_color,
   output logic [15:0]      color_out,
   output logic [IDX_W-1:0] seq_idx,
   output logic             busy,
   output logic             wrap
);

   led_state_e       state_q, state_d;
   logic [15:0]      color_q, color_d;
   logic [IDX_W-1:0] seq_idx_q, seq_idx_d;
   logic             busy_q, busy_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [15:0]      palette_q [NUM_ENTRIES];

   logic [15:0]      tgt;
   logic             step_hit;
   logic [R_W-1:0]   r_next;
   logic [G_W-1:0]   g_next;
   logic [B_W-1:0]   b_next;
   logic             r_at, g_at, b_at;
   logic             at_all;

   assign tgt      = palette_q[seq_idx_q];
   assign step_hit = (step_q == CNT_W'(STEP_CYCLES - 1));
   assign at_all   = r_at & g_at & b_at;

   led_channel_ramp #(.W(R_W)) u_ramp_r (
      .cur     (color_q[R_MSB:R_LSB]),
      .tgt     (tgt[R_MSB:R_LSB]),
      .step_en (step_hit),
      .next    (r_next),
      .at_tgt  (r_at)
   );

   led_channel_ramp #(.W(G_W)) u_ramp_g (
      .cur     (color_q[G_MSB:G_LSB]),
      .tgt     (tgt[G_MSB:G_LSB]),
      .step_en (step_hit),
      .next    (g_next),
      .at_tgt  (g_at)
   );

   led_channel_ramp #(.W(B_W)) u_ramp_b (
      .cur     (color_q[B_MSB:B_LSB]),
      .tgt     (tgt[B_MSB:B_LSB]),
      .step_en (step_hit),
      .next    (b_next),
      .at_tgt  (b_at)
   );

   always_comb begin
      state_d   = state_q;
      color_d   = color_q;
      seq_idx_d = seq_idx_q;
      step_d    = step_q;
      dwell_d   = dwell_q;
      wrap_d    = 1'b0;
      case (state_q)
         IDLE: begin
            color_d = switchPanel;
            // The last manual colour stays put as the origin of the first fade.
            if (start && !stop) begin
               state_d   = FADE;
               seq_idx_d = '0;
               step_d    = '0;
               color_d   = color_q;
            end
         end
         FADE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (at_all) begin
               state_d = HOLD;
               dwell_d = '0;
            end else begin
               color_d = {r_next, g_next, b_next};
               step_d  = step_hit ? '0 : step_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (stop) begin
               state_d = IDLE;
            end else if (dwell_q == CNT_W'(DWELL_CYCLES - 1)) begin
               state_d   = FADE;
               seq_idx_d = seq_idx_q + IDX_W'(1);
               wrap_d    = (seq_idx_q == IDX_W'(NUM_ENTRIES - 1));
               step_d    = '0;
            end else begin
               dwell_d = dwell_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         color_q   <= '0;
         seq_idx_q <= '0;
         busy_q    <= 1'b0;
         wrap_q    <= 1'b0;
         step_q    <= '0;
         dwell_q   <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            palette_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         color_q   <= color_d;
         seq_idx_q <= seq_idx_d;
         busy_q    <= busy_d;
         wrap_q    <= wrap_d;
         step_q    <= step_d;
         dwell_q   <= dwell_d;
         if (wr_en) begin
            palette_q[wr_idx] <= wr_color;
         end
      end
   end

   assign color_out = color_q;
   assign seq_idx   = seq_idx_q;
   assign busy      = busy_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_color_sequencer.sv
// tb/tb_led_color_sequencer.sv - directed and random checks of led_color_sequencer
module tb_led_color_sequencer;

   localparam int N     = 4;
   localparam int STEP  = 2;
   localparam int DWELL = 4;

   logic        clk = 1'b0;
   logic        rst, start, stop, wr_en;
   logic [1:0]  wr_idx;
   logic [15:0] sw, wr_color;
   logic [15:0] color_out;
   logic [1:0]  seq_idx;
   logic        busy, wrap;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: mode 0 manual, 1 fading, 2 holding; age counts cycles spent in the mode.
   int m_mode, m_r, m_g, m_b, m_idx, m_age, m_wrap;
   int m_pal [N];

   always #5 clk = ~clk;

   led_color_sequencer #(
      .NUM_ENTRIES (4),
      .IDX_W       (2),
      .STEP_CYCLES (STEP),
      .DWELL_CYCLES(DWELL),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .switchPanel(sw),
      .start      (start),
      .stop       (stop),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_color   (wr_color),
      .color_out  (color_out),
      .seq_idx    (seq_idx),
      .busy       (busy),
      .wrap       (wrap)
   );

   function automatic logic [15:0] pack(int r, int g, int b);
      return 16'((r << 11) | (g << 5) | b);
   endfunction

   function automatic int toward(int c, int t);
      if (t > c) return c + 1;
      if (t < c) return c - 1;
      return c;
   endfunction

   task automatic model_step();
      int tr, tg, tb;
      if (!rst) begin
         m_mode = 0; m_r = 0; m_g = 0; m_b = 0;
         m_idx = 0; m_age = 0; m_wrap = 0;
         for (int i = 0; i < N; i++) m_pal[i] = 0;
         return;
      end
      m_wrap = 0;
      tr = (m_pal[m_idx] >> 11) & 31;
      tg = (m_pal[m_idx] >> 5) & 63;
      tb = m_pal[m_idx] & 31;
      case (m_mode)
         0: begin
            if (start && !stop) begin
               m_mode = 1; m_idx = 0; m_age = 0;
            end else begin
               m_r = int'(sw[15:11]); m_g = int'(sw[10:5]); m_b = int'(sw[4:0]);
            end
         end
         1: begin
            if (stop) m_mode = 0;
            else if (m_r == tr && m_g == tg && m_b == tb) begin
               m_mode = 2; m_age = 0;
            end else begin
               if (m_age % STEP == STEP - 1) begin
                  m_r = toward(m_r, tr); m_g = toward(m_g, tg); m_b = toward(m_b, tb);
               end
               m_age++;
            end
         end
         default: begin
            if (stop) m_mode = 0;
            else if (m_age == DWELL - 1) begin
               m_idx  = (m_idx + 1) % N;
               m_wrap = (m_idx == 0) ? 1 : 0;
               m_mode = 1; m_age = 0;
            end else m_age++;
         end
      endcase
      if (wr_en) m_pal[int'(wr_idx)] = int'(wr_color);
   endtask

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bound_ok(string tag, bit found);
      n_tests++;
      assert (found) else begin
         n_fail++;
         $error("FAIL %s: observed timeout expected event", tag);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("color_out", color_out, pack(m_r, m_g, m_b));
      chk("seq_idx", 16'(seq_idx), 16'(m_idx));
      chk("busy", 16'(busy), 16'(m_mode != 0));
      chk("wrap", 16'(wrap), 16'(m_wrap));
   endtask

   task automatic write_pal(int idx, logic [15:0] c);
      wr_en = 1'b1; wr_idx = 2'(idx); wr_color = c;
      cycle();
      wr_en = 1'b0;
   endtask

   initial begin
      int wraps, max_b, max_g;
      bit found;

      rst = 1'b0; start = 1'b1; stop = 1'b0; wr_en = 1'b1;
      wr_idx = 2'd0; wr_color = 16'(($urandom() | 1));
      sw = 16'(($urandom() | 1));
      repeat (3) cycle();
      chk("reset_color", color_out, 16'h0000);

      rst = 1'b1; start = 1'b0; wr_en = 1'b0;
      sw = 16'hF800; cycle();
      chk("manual_F800", color_out, 16'hF800);
      sw = 16'h07E0; cycle();
      chk("manual_07E0", color_out, 16'h07E0);

      sw = 16'h0000; cycle();
      write_pal(0, 16'h1800);
      start = 1'b1; cycle(); start = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (m_mode == 2) begin
            found = 1;
            chk("hold_color", color_out, 16'h1800);
         end
      end
      bound_ok("reach_hold", found);
      repeat (8) cycle();

      stop = 1'b1; cycle(); stop = 1'b0;
      sw = 16'h0000; cycle();
      write_pal(0, 16'h0001);
      write_pal(1, 16'h0000);
      write_pal(2, 16'h0020);
      write_pal(3, 16'h0000);
      start = 1'b1; cycle(); start = 1'b0;
      wraps = 0; max_b = 0; max_g = 0; found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle();
         if (wrap) wraps++;
         if (int'(color_out[4:0]) > max_b) max_b = int'(color_out[4:0]);
         if (int'(color_out[10:5]) > max_g) max_g = int'(color_out[10:5]);
         if (m_wrap != 0) found = 1;
      end
      bound_ok("reach_wrap", found);
      repeat (5) begin
         cycle();
         if (wrap) wraps++;
      end
      chk("wrap_count", 16'(wraps), 16'd1);
      chk("max_b", 16'(max_b), 16'd1);
      chk("max_g", 16'(max_g), 16'd1);

      stop = 1'b1; cycle(); stop = 1'b0;
      write_pal(0, 16'hF81F);
      start = 1'b1; cycle(); start = 1'b0;
      repeat (3) cycle();
      start = 1'b1; cycle(); start = 1'b0;
      repeat (2) cycle();
      sw = 16'h5A5A;
      stop = 1'b1; cycle(); stop = 1'b0;
      chk("stop_busy", 16'(busy), 16'd0);
      cycle();
      chk("stop_follow", color_out, 16'h5A5A);

      write_pal(0, 16'h5A5A);
      start = 1'b1; cycle(); start = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (m_mode == 2) found = 1;
      end
      bound_ok("hold_for_startstop", found);
      start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
      chk("startstop_idle", 16'(busy), 16'd0);

      sw = 16'h0000; cycle(); cycle();
      write_pal(0, 16'h0000);
      write_pal(1, 16'h001F);
      start = 1'b1; cycle(); start = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (m_idx == 1 && m_mode == 1 && m_b == 1) found = 1;
      end
      bound_ok("reach_rewrite_point", found);
      write_pal(1, 16'h0002);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (m_mode == 2) found = 1;
      end
      bound_ok("rewrite_hold", found);
      chk("rewrite_color", color_out, 16'h0002);

      write_pal(2, 16'hFFFF);
      repeat (DWELL + 3) cycle();
      rst = 1'b0; cycle(); rst = 1'b1;
      chk("midfade_reset", color_out, 16'h0000);

      for (int i = 0; i < 500; i++) begin
         rst      = ($urandom_range(0, 199) != 0);
         start    = ($urandom_range(0, 19) == 0);
         stop     = ($urandom_range(0, 39) == 0);
         wr_en    = ($urandom_range(0, 9) == 0);
         wr_idx   = 2'($urandom_range(0, 3));
         wr_color = 16'($urandom());
         sw       = 16'($urandom());
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
